// File: rtl/sdram_scan_pkg.sv
// rtl/sdram_scan_pkg.sv - state encoding and word-size/extreme-value helpers for the SDRAM scan master
package sdram_scan_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic int unsigned BYTES_PER_WORD(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Extremes are built 64 bits wide; callers keep the low data_w bits.
    function automatic logic [63:0] ext_max(input int unsigned data_w, input bit is_signed);
        logic [63:0] ones;
        ones = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
        return is_signed ? (ones >> 1) : ones;
    endfunction

    function automatic logic [63:0] ext_min(input int unsigned data_w, input bit is_signed);
        logic [63:0] ones;
        ones = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
        return is_signed ? ~(ones >> 1) : 64'd0;
    endfunction

endpackage

// File: rtl/sdram_scan_cmp.sv
// rtl/sdram_scan_cmp.sv - registered min/max datapath; SDRAM_SCAN_SUM_EN adds a running sum
module sdram_scan_cmp
    import sdram_scan_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int SIGNED = 0
`ifdef SDRAM_SCAN_SUM_EN
    ,
    parameter int CNT_W  = 24
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] min_o,
`ifdef SDRAM_SCAN_SUM_EN
    output logic [DATA_W+CNT_W-1:0] sum_o,
`endif
    output logic [DATA_W-1:0] max_o
);

    localparam logic [63:0]       MAX64 = ext_max(DATA_W, SIGNED != 0);
    localparam logic [63:0]       MIN64 = ext_min(DATA_W, SIGNED != 0);
    localparam logic [DATA_W-1:0] MAX_V = MAX64[DATA_W-1:0];
    localparam logic [DATA_W-1:0] MIN_V = MIN64[DATA_W-1:0];
    localparam logic              FLIP  = (SIGNED != 0);

    logic [DATA_W-1:0] min_q, min_d, max_q, max_d;
    logic [DATA_W-1:0] key_data, key_min, key_max;

    // Inverting the sign bit maps two's-complement order onto unsigned order.
    assign key_data = {data_i[DATA_W-1] ^ FLIP, data_i[DATA_W-2:0]};
    assign key_min  = {min_q[DATA_W-1] ^ FLIP, min_q[DATA_W-2:0]};
    assign key_max  = {max_q[DATA_W-1] ^ FLIP, max_q[DATA_W-2:0]};

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clear_i) begin
            min_d = MAX_V;
            max_d = MIN_V;
        end else if (valid_i) begin
            if (key_data < key_min) min_d = data_i;
            if (key_data > key_max) max_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q <= MAX_V;
            max_q <= MIN_V;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;

`ifdef SDRAM_SCAN_SUM_EN
    logic [DATA_W+CNT_W-1:0] sum_q, sum_d;
    logic [DATA_W+CNT_W-1:0] data_ext;

    assign data_ext = {{CNT_W{FLIP & data_i[DATA_W-1]}}, data_i};

    always_comb begin
        sum_d = sum_q;
        if (clear_i)      sum_d = '0;
        else if (valid_i) sum_d = sum_q + data_ext;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end

    assign sum_o = sum_q;
`endif

endmodule

// File: rtl/sdram_scan_master.sv
// rtl/sdram_scan_master.sv - pipelined Avalon-MM read master scanning SDRAM for min/max; SDRAM_SCAN_SUM_EN adds sum_out
module sdram_scan_master
    import sdram_scan_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 32,
    parameter int CNT_W    = 24,
    parameter int MAX_PEND = 4,
    parameter int SIGNED   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ready_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [CNT_W-1:0]  word_count_in,
    output logic              done_out,
    output logic              busy_out,
    output logic [1:0]        state_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
`ifdef SDRAM_SCAN_SUM_EN
    output logic [DATA_W+CNT_W-1:0] sum_out,
`endif
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid
);

    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(BYTES_PER_WORD(DATA_W));
    localparam logic [3:0]        MAXP      = 4'(MAX_PEND);

    state_e            state_q, state_d;
    logic              ready_q, ready_prev_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CNT_W-1:0]  issued_q, issued_d;
    logic [3:0]        pending_q, pending_d;

    logic start, busy, rd_req, accept, ret;

    assign start  = ready_q & ~ready_prev_q & (state_q == S_IDLE);
    assign busy   = (state_q == S_READ) || (state_q == S_DRAIN);
    // Request is a function of registers only, so it cannot drop during a stall.
    assign rd_req = (state_q == S_READ) && (issued_q < count_q) && (pending_q < MAXP);
    assign accept = rd_req & ~avm_waitrequest;
    // Responses outside an active scan, or with nothing outstanding, are stale.
    assign ret    = busy & avm_readdatavalid & (pending_q != 4'd0);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        issued_d = issued_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr_in;
                    count_d  = word_count_in;
                    issued_d = '0;
                    state_d  = (word_count_in == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (accept) begin
                    addr_d   = addr_q + ADDR_STEP;
                    issued_d = issued_q + CNT_W'(1);
                    if (issued_q + CNT_W'(1) == count_q) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pending_q == 4'd0) state_d = S_DONE;
            end
            S_DONE: begin
                if (!ready_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pending_d = pending_q;
        case ({accept, ret})
            2'b10:   pending_d = pending_q + 4'd1;
            2'b01:   pending_d = pending_q - 4'd1;
            default: pending_d = pending_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            ready_q      <= 1'b0;
            ready_prev_q <= 1'b0;
            addr_q       <= '0;
            count_q      <= '0;
            issued_q     <= '0;
            pending_q    <= '0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_in;
            ready_prev_q <= ready_q;
            addr_q       <= addr_d;
            count_q      <= count_d;
            issued_q     <= issued_d;
            pending_q    <= pending_d;
        end
    end

    sdram_scan_cmp #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
`ifdef SDRAM_SCAN_SUM_EN
        ,
        .CNT_W  (CNT_W)
`endif
    ) u_cmp (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (start),
        .valid_i (ret),
        .data_i  (avm_readdata),
        .min_o   (min_out),
`ifdef SDRAM_SCAN_SUM_EN
        .sum_o   (sum_out),
`endif
        .max_o   (max_out)
    );

    assign done_out    = (state_q == S_DONE);
    assign busy_out    = busy;
    assign state_out   = state_q;
    assign avm_address = addr_q;
    assign avm_read    = rd_req;

endmodule
